// File: rtl/if_fetch_if.sv
// Instruction-memory request/acknowledge channel between the fetch front end and imem.
// The fetch unit owns req/addr; imem answers with ack/data, possibly in the same cycle.
interface if_fetch_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_data_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ack_i,
      input  imem_data_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ack_i,
      output imem_data_i
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch front end feeding the IF/ID register: owns the PC, runs the imem
// handshake, absorbs stalls, applies ID-stage redirects and drops wrong-path responses.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        hazard_stall_i,
   input  logic        mem_stall_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   if_fetch_if.master  imem,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        flush_o,
   output logic        hold_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLD
   } state_t;

   state_t      r_state;
   logic [31:0] r_req_addr;
   logic [31:0] r_pc;
   logic        r_drop;
   logic [31:0] r_buf;

   logic        w_stall;
   logic        w_redirect;
   logic        w_ack;
   logic [31:0] w_target_raw;
   logic [31:0] w_target;

   assign w_stall      = hazard_stall_i | mem_stall_i;
   assign w_redirect   = (branch_i | jump_i) & ~w_stall & (r_state != S_IDLE);
   assign w_ack        = (r_state == S_REQ) & imem.imem_ack_i;
   assign w_target_raw = jump_i ? jump_target_i : branch_target_i;
   assign w_target     = {w_target_raw[31:2], 2'b00};

   // Address and request come straight from state, so they cannot move while waiting for ack.
   assign imem.imem_req_o  = (r_state == S_REQ);
   assign imem.imem_addr_o = {r_req_addr[31:2], 2'b00};
   assign pc_o             = r_req_addr + 32'd4;
   assign inst_o           = (w_ack & ~r_drop) ? imem.imem_data_i : r_buf;
   assign flush_o          = w_redirect;

   // NOTE: assign a default before the case so every path drives hold_o and no latch is inferred.
   always_comb begin
      hold_o = 1'b1;
      case (r_state)
         S_REQ:   hold_o = ~(w_redirect | (w_ack & ~r_drop & ~w_stall));
         S_HOLD:  hold_o = w_stall;
         default: hold_o = 1'b1;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= S_IDLE;
         r_req_addr <= RESET_PC;
         r_pc       <= RESET_PC;
         r_drop     <= 1'b0;
         r_buf      <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_REQ;

            S_REQ: begin
               if (w_redirect) begin
                  r_pc <= w_target;
                  if (imem.imem_ack_i) begin
                     r_req_addr <= w_target;
                     r_drop     <= 1'b0;
                  end else begin
                     // Request already on the bus must complete; its data is thrown away.
                     r_drop <= 1'b1;
                  end
               end else if (imem.imem_ack_i) begin
                  if (r_drop) begin
                     r_drop     <= 1'b0;
                     r_req_addr <= r_pc;
                  end else if (w_stall) begin
                     r_buf   <= imem.imem_data_i;
                     r_state <= S_HOLD;
                  end else begin
                     r_req_addr <= r_req_addr + 32'd4;
                  end
               end
            end

            S_HOLD: begin
               if (w_redirect) begin
                  r_pc       <= w_target;
                  r_req_addr <= w_target;
                  r_state    <= S_REQ;
               end else if (!w_stall) begin
                  r_req_addr <= r_req_addr + 32'd4;
                  r_state    <= S_REQ;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch front end directly upstream of the IF/ID pipeline register. Owns the program counter, issues requests to instruction memory over a req/ack handshake with variable latency, and drives the IF/ID register's pc, instruction, flush and write-hold inputs. It absorbs pipeline stalls (load-use and data-memory), redirects on branches and jumps resolved in ID, and discards wrong-path responses already in flight.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- hazard_stall_i  in  1  load-use stall from hazard detection; hold fetch
- mem_stall_i  in  1  data-memory stall; freeze front end, ignore redirects
- branch_i  in  1  taken branch resolved in ID (1-cycle pulse)
- branch_target_i  in  32  branch target
- jump_i  in  1  jump in ID (1-cycle pulse)
- jump_target_i  in  32  jump target
- imem_req_o  out  1  instruction request
- imem_addr_o  out  32  request address (word aligned)
- imem_ack_i  in  1  response valid, may be same cycle as req
- imem_data_i  in  32  instruction word, valid with ack
- pc_o  out  32  fetched address + 4, to IF/ID pc_i
- inst_o  out  32  fetched instruction, to IF/ID inst_i
- flush_o  out  1  to IF/ID flush_i; load NOP
- hold_o  out  1  to IF/ID write_i; 1 = IF/ID keeps contents, 0 = IF/ID loads

## Operation
- State: FSM {IDLE, REQ, HOLD}; req_addr_q (outstanding address), pc_q (next address to fetch), drop_q, buf_q (32-bit instruction buffer).
- Reset: state IDLE, req_addr_q = pc_q = RESET_PC, drop_q = 0, buf_q = 0. Outputs: imem_req_o 0, imem_addr_o RESET_PC, pc_o RESET_PC+4, inst_o 0, flush_o 0, hold_o 1.
- IDLE: one cycle after reset release, then REQ.
- REQ: imem_req_o = 1, imem_addr_o = req_addr_q; both stay stable until ack (handshake rule, no withdrawal).
- Stall = hazard_stall_i | mem_stall_i. redirect = (branch_i | jump_i) & ~stall; jump_i wins if both.
- REQ, ack, no stall, no redirect, drop_q = 0: hold_o = 0, inst_o = imem_data_i; req_addr_q <= req_addr_q+4; stay REQ.
- REQ, ack, stall, drop_q = 0: buf_q <= imem_data_i; go HOLD; hold_o = 1.
- REQ, no ack: hold_o = 1 unless redirect.
- HOLD: inst_o = buf_q, req low; stall -> stay; no stall -> hold_o = 0, req_addr_q += 4, go REQ.
- Redirect (any state but IDLE): flush_o = 1, hold_o = 0 (IF/ID loads NOP); pc_q <= target. If REQ with no ack: drop_q <= 1, stay REQ at old address. Otherwise (ack same cycle, or HOLD): response/buffer discarded, req_addr_q <= target, go REQ.
- REQ, ack, drop_q = 1: data discarded, hold_o = 1, drop_q <= 0, req_addr_q <= pc_q.
- pc_o = req_addr_q + 4 in every state (32-bit wrap, no overflow flag).
- Address bits [1:0] of targets ignored (forced 0 on imem_addr_o).

## Timing
- First request in cycle 1 after reset release (IDLE occupies cycle 0).
- Zero-wait memory (ack with req): one instruction per cycle, hold_o low every cycle.
- Fetch latency: IF/ID captures in the ack cycle; N-cycle memory gives N-1 hold cycles.
- Taken branch/jump with zero-wait memory: 1 NOP bubble; target requested the cycle after redirect.
- Redirect during mem_stall_i or hazard_stall_i: ignored (ID re-presents it).
- Async reset mid-transaction: state cleared immediately; outstanding response is not tracked (imem must also be reset).

## Test plan
- Reset RESET_PC=0x100, zero-wait imem: imem_addr_o 0x100,0x104,0x108 in cycles 1-3; pc_o 0x104,0x108,0x10C; hold_o 0.
- 3-cycle imem latency: hold_o 1 for 2 cycles, 0 in ack cycle; addr stable across wait.
- hazard_stall_i 2 cycles during ack: inst buffered, hold_o 1 two cycles, then buffer delivered, next req at +4.
- branch_i to 0x200 with ack same cycle: flush_o 1, hold_o 0; next cycle imem_addr_o 0x200.
- branch_i to 0x200 while 3-cycle fetch of 0x10C pending: addr stays 0x10C until ack, data dropped (hold_o 1), then req 0x200.
- mem_stall_i with branch_i: no flush, PC unchanged; rst_i low mid-fetch: outputs return to reset values immediately.
